// File: rtl/hazard_scheduler.sv
// Hazard controller for the 5-stage RV32I pipeline: operand forwarding selects,
// load-use bubble insertion, data-memory freeze with timeout, and a stall counter.
module hazard_scheduler #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_MEM_WAIT   = 15
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [REG_ADDR_WIDTH-1:0] ID_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] ID_rs2,
  input  logic                      ID_uses_rs1,
  input  logic                      ID_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] EX_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] EX_rs2,
  input  logic                      EX_uses_rs1,
  input  logic                      EX_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] EX_rd,
  input  logic                      EX_reg_write,
  input  logic [6:0]                EX_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] MEM_rd,
  input  logic                      MEM_reg_write,
  input  logic                      MEM_mem_req,
  input  logic                      dmem_ready,
  input  logic [REG_ADDR_WIDTH-1:0] WB_rd,
  input  logic                      WB_reg_write,
  output logic [1:0]                hazard_op,
  output logic [1:0]                wb_hazard_op,
  output logic                      pc_stall,
  output logic                      IF_ID_stall,
  output logic                      ID_EX_stall,
  output logic                      ID_EX_flush,
  output logic                      EX_MEM_stall,
  output logic                      MEM_WB_flush,
  output logic                      mem_timeout,
  output logic [31:0]               stall_cycle_count
);

  localparam logic [6:0] OPCODE_LOAD = 7'b0000011;
  localparam logic [7:0] MAX_WAIT    = 8'(MAX_MEM_WAIT);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = {REG_ADDR_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    LOAD_BUBBLE = 2'd1,
    MEM_WAIT    = 2'd2,
    TIMEOUT     = 2'd3
  } state_t;

  state_t     state_r;
  logic [7:0] wait_cnt_r;
  logic [7:0] wait_nxt_s;
  logic       mem_busy_s;
  logic       load_use_s;
  logic       freeze_s;
  logic       bubble_s;
  logic       mem_fwd1_s, mem_fwd2_s, wb_fwd1_s, wb_fwd2_s;

  function automatic logic fwd_match(input logic wr, input logic [REG_ADDR_WIDTH-1:0] rd,
                                     input logic [REG_ADDR_WIDTH-1:0] src, input logic uses);
    return wr & (rd != REG_ZERO) & (rd == src) & uses;
  endfunction

  assign mem_busy_s = MEM_mem_req & ~dmem_ready;
  assign load_use_s = (EX_opcode == OPCODE_LOAD) & EX_reg_write & (EX_rd != REG_ZERO) &
                      ((ID_uses_rs1 & (ID_rs1 == EX_rd)) | (ID_uses_rs2 & (ID_rs2 == EX_rd)));
  assign wait_nxt_s = wait_cnt_r + 8'd1;

  assign mem_fwd1_s = fwd_match(MEM_reg_write, MEM_rd, EX_rs1, EX_uses_rs1);
  assign mem_fwd2_s = fwd_match(MEM_reg_write, MEM_rd, EX_rs2, EX_uses_rs2);
  assign wb_fwd1_s  = fwd_match(WB_reg_write, WB_rd, EX_rs1, EX_uses_rs1);
  assign wb_fwd2_s  = fwd_match(WB_reg_write, WB_rd, EX_rs2, EX_uses_rs2);

  // Freeze/bubble decision from state; the release cycle of MEM_WAIT re-checks load-use.
  always_comb begin
    freeze_s = 1'b0;
    bubble_s = 1'b0;
    case (state_r)
      RUN, MEM_WAIT: begin
        if (mem_busy_s) begin
          freeze_s = 1'b1;
        end else if (load_use_s) begin
          bubble_s = 1'b1;
        end else begin
          bubble_s = 1'b0;
        end
      end
      LOAD_BUBBLE: begin
        if (mem_busy_s) begin
          freeze_s = 1'b1;
        end else begin
          freeze_s = 1'b0;
        end
      end
      TIMEOUT: freeze_s = 1'b1;
      default: freeze_s = 1'b1;
    endcase
  end

  // Output drive; everything combinational is held at zero while in reset.
  always_comb begin
    hazard_op    = 2'b00;
    wb_hazard_op = 2'b00;
    pc_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    ID_EX_stall  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_stall = 1'b0;
    MEM_WB_flush = 1'b0;
    if (reset_n) begin
      hazard_op    = {mem_fwd2_s, mem_fwd1_s};
      wb_hazard_op = {wb_fwd2_s & ~mem_fwd2_s, wb_fwd1_s & ~mem_fwd1_s};
      pc_stall     = freeze_s | bubble_s;
      IF_ID_stall  = freeze_s | bubble_s;
      ID_EX_stall  = freeze_s;
      ID_EX_flush  = bubble_s;
      EX_MEM_stall = freeze_s;
      MEM_WB_flush = freeze_s;
    end else begin
      hazard_op    = 2'b00;
      wb_hazard_op = 2'b00;
    end
  end

  // Scheduler state, memory-wait counter, sticky timeout and stall counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r           <= RUN;
      wait_cnt_r        <= 8'd0;
      mem_timeout       <= 1'b0;
      stall_cycle_count <= 32'd0;
    end else begin
      if (pc_stall && (stall_cycle_count != 32'hFFFF_FFFF)) begin
        stall_cycle_count <= stall_cycle_count + 32'd1;
      end
      case (state_r)
        RUN, LOAD_BUBBLE: begin
          if (mem_busy_s) begin
            wait_cnt_r <= 8'd1;
            if (8'd1 >= MAX_WAIT) begin
              state_r     <= TIMEOUT;
              mem_timeout <= 1'b1;
            end else begin
              state_r <= MEM_WAIT;
            end
          end else if ((state_r == RUN) && load_use_s) begin
            state_r <= LOAD_BUBBLE;
          end else begin
            state_r <= RUN;
          end
        end
        MEM_WAIT: begin
          if (mem_busy_s) begin
            wait_cnt_r <= wait_nxt_s;
            if (wait_nxt_s >= MAX_WAIT) begin
              state_r     <= TIMEOUT;
              mem_timeout <= 1'b1;
            end
          end else begin
            wait_cnt_r <= 8'd0;
            state_r    <= load_use_s ? LOAD_BUBBLE : RUN;
          end
        end
        TIMEOUT: mem_timeout <= 1'b1;
        default: state_r <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler: directed scenarios plus randomized traffic
// checked against a behavioural model of the hazard rules.
module tb_hazard_scheduler;

  localparam int MAXW = 15;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2;
    logic       id_u1, id_u2;
    logic [4:0] ex_rs1, ex_rs2;
    logic       ex_u1, ex_u2;
    logic [4:0] ex_rd;
    logic       ex_rw;
    logic [6:0] ex_op;
    logic [4:0] mem_rd;
    logic       mem_rw, mem_req, rdy;
    logic [4:0] wb_rd;
    logic       wb_rw;
  } stim_t;

  typedef struct packed {
    logic [1:0]  hop;
    logic [1:0]  whop;
    logic        pc_st, ifid_st, idex_st, idex_fl, exmem_st, memwb_fl;
    logic        tmo;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  stim_t cur;
  logic [1:0] hazard_op, wb_hazard_op;
  logic pc_stall, IF_ID_stall, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush, mem_timeout;
  logic [31:0] stall_cycle_count;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // model state
  bit          timed_out;
  int          busy_run;
  bit          just_bubbled;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_scheduler #(.REG_ADDR_WIDTH(5), .MAX_MEM_WAIT(MAXW)) dut (
    .clk(clk), .reset_n(cur.rst_n),
    .ID_rs1(cur.id_rs1), .ID_rs2(cur.id_rs2), .ID_uses_rs1(cur.id_u1), .ID_uses_rs2(cur.id_u2),
    .EX_rs1(cur.ex_rs1), .EX_rs2(cur.ex_rs2), .EX_uses_rs1(cur.ex_u1), .EX_uses_rs2(cur.ex_u2),
    .EX_rd(cur.ex_rd), .EX_reg_write(cur.ex_rw), .EX_opcode(cur.ex_op),
    .MEM_rd(cur.mem_rd), .MEM_reg_write(cur.mem_rw), .MEM_mem_req(cur.mem_req),
    .dmem_ready(cur.rdy), .WB_rd(cur.wb_rd), .WB_reg_write(cur.wb_rw),
    .hazard_op(hazard_op), .wb_hazard_op(wb_hazard_op), .pc_stall(pc_stall),
    .IF_ID_stall(IF_ID_stall), .ID_EX_stall(ID_EX_stall), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_stall(EX_MEM_stall), .MEM_WB_flush(MEM_WB_flush),
    .mem_timeout(mem_timeout), .stall_cycle_count(stall_cycle_count)
  );

  function automatic bit fwd(input logic wr, input logic [4:0] rd, input logic [4:0] src, input logic uses);
    return wr && rd != 5'd0 && rd == src && uses;
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    bit m1, m2, busy, lu, frz, bub;
    e = '0;
    e.tmo = timed_out;
    e.cnt = stall_cnt;
    if (s.rst_n) begin
      m1 = fwd(s.mem_rw, s.mem_rd, s.ex_rs1, s.ex_u1);
      m2 = fwd(s.mem_rw, s.mem_rd, s.ex_rs2, s.ex_u2);
      e.hop  = {m2, m1};
      e.whop = {!m2 && fwd(s.wb_rw, s.wb_rd, s.ex_rs2, s.ex_u2),
                !m1 && fwd(s.wb_rw, s.wb_rd, s.ex_rs1, s.ex_u1)};
      busy = s.mem_req && !s.rdy;
      lu   = s.ex_op == OP_LOAD && s.ex_rw && s.ex_rd != 5'd0 &&
             ((s.id_u1 && s.id_rs1 == s.ex_rd) || (s.id_u2 && s.id_rs2 == s.ex_rd));
      frz  = timed_out || busy;
      bub  = !frz && lu && !just_bubbled;
      e.pc_st = frz || bub;   e.ifid_st = frz || bub;
      e.idex_st = frz;        e.idex_fl = bub;
      e.exmem_st = frz;       e.memwb_fl = frz;
    end
    return e;
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    cur = s;
    e = predict(s);
    exp_q.push_back(e);
    @(posedge clk);
    if (!s.rst_n) begin
      timed_out = 0; busy_run = 0; just_bubbled = 0; stall_cnt = 32'd0;
    end else begin
      if (e.pc_st && stall_cnt != 32'hFFFF_FFFF) stall_cnt = stall_cnt + 32'd1;
      if (!timed_out) begin
        if (s.mem_req && !s.rdy) begin
          busy_run++;
          if (busy_run >= MAXW) timed_out = 1;
        end else begin
          busy_run = 0;
        end
      end
      just_bubbled = e.idex_fl;
    end
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    s.ex_op = OP_ALU;
    return s;
  endfunction

  function automatic stim_t rnd(input int rdy_pct);
    stim_t s;
    s.rst_n  = ($urandom_range(0, 59) != 0);
    s.id_rs1 = 5'($urandom_range(0, 3));  s.id_rs2 = 5'($urandom_range(0, 3));
    s.id_u1  = 1'($urandom_range(0, 1));  s.id_u2  = 1'($urandom_range(0, 1));
    s.ex_rs1 = 5'($urandom_range(0, 3));  s.ex_rs2 = 5'($urandom_range(0, 3));
    s.ex_u1  = 1'($urandom_range(0, 1));  s.ex_u2  = 1'($urandom_range(0, 1));
    s.ex_rd  = 5'($urandom_range(0, 3));  s.ex_rw  = 1'($urandom_range(0, 1));
    s.ex_op  = ($urandom_range(0, 2) == 0) ? OP_ALU : OP_LOAD;
    s.mem_rd = 5'($urandom_range(0, 3));  s.mem_rw = 1'($urandom_range(0, 1));
    s.mem_req = ($urandom_range(0, 3) != 0);
    s.rdy    = ($urandom_range(0, 99) < rdy_pct);
    s.wb_rd  = 5'($urandom_range(0, 3));  s.wb_rw  = 1'($urandom_range(0, 1));
    return s;
  endfunction

  // Monitor: every cycle the DUT presents a full output set; compare with the oldest prediction.
  initial begin
    exp_t e, got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {hazard_op, wb_hazard_op, pc_stall, IF_ID_stall, ID_EX_stall, ID_EX_flush,
               EX_MEM_stall, MEM_WB_flush, mem_timeout, stall_cycle_count};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs @%0t: got hop=%b whop=%b st=%b%b%b fl=%b st=%b fl=%b tmo=%b cnt=%0d, need hop=%b whop=%b st=%b%b%b fl=%b st=%b fl=%b tmo=%b cnt=%0d",
                   $time, got.hop, got.whop, got.pc_st, got.ifid_st, got.idex_st, got.idex_fl,
                   got.exmem_st, got.memwb_fl, got.tmo, got.cnt,
                   e.hop, e.whop, e.pc_st, e.ifid_st, e.idex_st, e.idex_fl,
                   e.exmem_st, e.memwb_fl, e.tmo, e.cnt);
        end
      end
    end
  end

  initial begin
    stim_t s;
    int pct;
    cur = idle();
    cur.rst_n = 1'b0;
    timed_out = 0; busy_run = 0; just_bubbled = 0; stall_cnt = 32'd0;
    @(posedge clk); #1;

    // reset state
    s = idle(); s.rst_n = 1'b0; s.mem_req = 1'b1; s.ex_u1 = 1'b1; s.ex_rs1 = 5'd5;
    s.mem_rd = 5'd5; s.mem_rw = 1'b1;
    drive(s);

    // MEM beats WB on the same operand
    s = idle(); s.ex_rs1 = 5'd5; s.ex_u1 = 1'b1; s.mem_rd = 5'd5; s.mem_rw = 1'b1;
    s.wb_rd = 5'd5; s.wb_rw = 1'b1;
    drive(s);
    // x0 never forwards; WB forwards rs1
    s = idle(); s.ex_rs2 = 5'd0; s.ex_u2 = 1'b1; s.mem_rd = 5'd0; s.mem_rw = 1'b1;
    s.ex_rs1 = 5'd7; s.ex_u1 = 1'b1; s.wb_rd = 5'd7; s.wb_rw = 1'b1;
    drive(s);

    // load-use bubble, then load forwarded from MEM
    s = idle(); s.ex_op = OP_LOAD; s.ex_rd = 5'd3; s.ex_rw = 1'b1; s.id_rs2 = 5'd3; s.id_u2 = 1'b1;
    drive(s);
    s = idle(); s.ex_rs2 = 5'd3; s.ex_u2 = 1'b1; s.mem_rd = 5'd3; s.mem_rw = 1'b1;
    drive(s);

    // three-cycle memory wait
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.mem_req = 1'b1; s.rdy = (i == 3);
      drive(s);
    end
    drive(idle());

    // load-use together with a busy memory, then release
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.ex_op = OP_LOAD; s.ex_rd = 5'd4; s.ex_rw = 1'b1; s.id_rs1 = 5'd4; s.id_u1 = 1'b1;
      s.mem_req = 1'b1; s.rdy = (i >= 2);
      drive(s);
    end

    // timeout after MAX_MEM_WAIT busy cycles, persists, cleared by reset
    for (int i = 0; i < 20; i++) begin
      s = idle(); s.mem_req = 1'b1; s.rdy = 1'b0;
      drive(s);
    end
    s = idle(); s.mem_req = 1'b1; s.rdy = 1'b1;
    drive(s);
    s = idle(); s.rst_n = 1'b0;
    drive(s);
    drive(idle());

    // randomized traffic with varying memory readiness
    for (int blk = 0; blk < 15; blk++) begin
      pct = $urandom_range(10, 90);
      for (int i = 0; i < 200; i++) drive(rnd(pct));
    end

    cur = idle();
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left unchecked, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
